// File: rtl/trigger_receiver.sv
// Trigger receiver: accepts rising trigger edges while armed, tags each with a
// timestamp and sequence ID, hands it off over valid/ready, then holds off.
module trigger_receiver #(
    parameter int TS_WIDTH     = 32,
    parameter int ID_WIDTH     = 16,
    parameter int MISSED_WIDTH = 16,
    parameter int DEAD_CYCLES  = 8
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    arm_i,
    input  logic                    trigger_i,
    input  logic                    event_ready_i,
    output logic                    event_valid_o,
    output logic [TS_WIDTH-1:0]     event_ts_o,
    output logic [ID_WIDTH-1:0]     event_id_o,
    output logic                    busy_o,
    output logic [MISSED_WIDTH-1:0] missed_count_o
);

    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCW-1:0] DEAD_LAST = DCW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PENDING,
        S_DEAD
    } state_t;

    state_t              r_state;
    logic [TS_WIDTH-1:0] r_ts;
    logic                r_trig_q;
    logic [ID_WIDTH-1:0] r_id;
    logic [DCW-1:0]      r_dead_cnt;
    logic                w_rise;

    // Missed-trigger counter sticks at all-ones so the DAQ never sees a wrap.
    function automatic logic [MISSED_WIDTH-1:0] sat_inc(input logic [MISSED_WIDTH-1:0] v);
        return (&v) ? v : v + MISSED_WIDTH'(1);
    endfunction

    assign w_rise = trigger_i & ~r_trig_q;
    assign busy_o = (r_state == S_PENDING) || (r_state == S_DEAD);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts     <= '0;
            r_trig_q <= 1'b0;
        end else begin
            r_ts     <= r_ts + TS_WIDTH'(1);
            r_trig_q <= trigger_i;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state        <= S_IDLE;
            event_valid_o  <= 1'b0;
            event_ts_o     <= '0;
            event_id_o     <= '0;
            r_id           <= '0;
            r_dead_cnt     <= '0;
            missed_count_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_state        <= S_ARMED;
                        r_id           <= '0;
                        missed_count_o <= '0;
                    end
                end
                S_ARMED: begin
                    // Disarm takes priority over a coincident edge.
                    if (!arm_i) begin
                        r_state <= S_IDLE;
                    end else if (w_rise) begin
                        r_state       <= S_PENDING;
                        event_valid_o <= 1'b1;
                        event_ts_o    <= r_ts;
                        event_id_o    <= r_id;
                        r_id          <= r_id + ID_WIDTH'(1);
                    end
                end
                S_PENDING: begin
                    if (w_rise) begin
                        missed_count_o <= sat_inc(missed_count_o);
                    end
                    if (event_ready_i) begin
                        event_valid_o <= 1'b0;
                        if (DEAD_CYCLES > 0) begin
                            r_state    <= S_DEAD;
                            r_dead_cnt <= '0;
                        end else begin
                            r_state <= arm_i ? S_ARMED : S_IDLE;
                        end
                    end
                end
                S_DEAD: begin
                    if (w_rise) begin
                        missed_count_o <= sat_inc(missed_count_o);
                    end
                    if (r_dead_cnt == DEAD_LAST) begin
                        r_state <= arm_i ? S_ARMED : S_IDLE;
                    end else begin
                        r_dead_cnt <= r_dead_cnt + DCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
